// File: rtl/chacha20_pkg.sv
// Shared constants, host FSM state type and word-slicing helper for the
// ChaCha20 word-stream host.
package chacha20_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SEND  = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } host_state_t;

    // Word k of a block lives in bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] word_of(input logic [BLOCK_W-1:0] blk,
                                                   input logic [3:0]         idx);
        return blk[int'(idx)*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/chacha20_word_deserializer.sv
// 16x32 right-shifting capture register. Each enabled cycle the incoming
// word enters the top slot and everything moves down one word, so after 16
// shifts the first word received sits in [31:0].
module chacha20_word_deserializer
    import chacha20_pkg::*;
(
    input  logic               clk,
    input  logic               shift,
    input  logic [WORD_W-1:0]  din,
    output logic [BLOCK_W-1:0] q_shifted
);

    logic [BLOCK_W-1:0] capture;

    // Value the register takes if this cycle shifts; lets the host grab the
    // block including the word arriving together with done.
    assign q_shifted = {din, capture[BLOCK_W-1:WORD_W]};

    // Capture register; pure datapath, fully overwritten by 16 shifts, so no reset.
    always_ff @(posedge clk) begin
        if (shift) begin
            capture <= q_shifted;
        end
    end

endmodule

// File: rtl/chacha20_stream_host.sv
// Host-side driver for the ChaCha20 32-bit word-stream wrapper: accepts a
// 512-bit block, pulses start, streams 16 words out, collects 16 result
// words ending at done, and hands the block downstream, with a bounded wait.
module chacha20_stream_host
    import chacha20_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BLOCK_W-1:0] res_data,
    output logic               res_timeout,
    output logic               ws_start,
    output logic [WORD_W-1:0]  ws_data,
    input  logic [WORD_W-1:0]  ws_result,
    input  logic               ws_done,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    host_state_t        state;
    logic [3:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] blk_lat;
    logic [BLOCK_W-1:0] cap_next;
    logic               shift_en;
    logic               accept;

    // Capture runs every WAIT cycle; stray done or words outside WAIT never touch it.
    assign shift_en = (state == WAIT);
    assign accept   = (state == IDLE) && blk_ready && blk_valid;

    chacha20_word_deserializer u_deser (
        .clk       (clk),
        .shift     (shift_en),
        .din       (ws_result),
        .q_shifted (cap_next)
    );

    // Input block holding register; only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            blk_lat <= blk_data;
        end
    end

    // Host FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            blk_ready   <= 1'b0;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            res_data    <= '0;
            ws_start    <= 1'b0;
            ws_data     <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // blk_ready comes up one cycle after entering IDLE.
                    if (accept) begin
                        blk_ready <= 1'b0;
                        ws_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end else begin
                        blk_ready <= 1'b1;
                    end
                end
                START: begin
                    ws_start <= 1'b0;
                    ws_data  <= word_of(blk_lat, 4'd0);
                    idx      <= 4'd0;
                    state    <= SEND;
                end
                SEND: begin
                    // idx is the word currently on ws_data.
                    if (idx == 4'd15) begin
                        ws_data <= '0;
                        cnt     <= '0;
                        state   <= WAIT;
                    end else begin
                        ws_data <= word_of(blk_lat, idx + 4'd1);
                        idx     <= idx + 4'd1;
                    end
                end
                WAIT: begin
                    // done takes priority over an expiring counter.
                    if (ws_done) begin
                        res_data    <= cap_next;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b0;
                        state       <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        res_data    <= '0;
                        res_valid   <= 1'b1;
                        res_timeout <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        res_timeout <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha20_stream_host.sv
// Self-checking bench for chacha20_stream_host with a behavioural wrapper
// model (XOR 0xA5A5A5A5 per word, result words on the 16 cycles ending at done).
module tb_chacha20_stream_host;

    localparam int TO = 32;
    localparam logic [31:0] XKEY = 32'hA5A5A5A5;

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         res_valid;
    logic         res_ready;
    logic [511:0] res_data;
    logic         res_timeout;
    logic         ws_start;
    logic [31:0]  ws_data;
    logic [31:0]  ws_result;
    logic         ws_done;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_hs = 0;

    chacha20_stream_host #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_data    (blk_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_timeout (res_timeout),
        .ws_start    (ws_start),
        .ws_data     (ws_data),
        .ws_result   (ws_result),
        .ws_done     (ws_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom;
        return b;
    endfunction

    // One full transaction. d: WAIT-cycle index of done (-1 = never);
    // stray: SEND word index during which a stray done is pulsed (-1 = none);
    // hold: cycles res_ready stays low once the result appears;
    // b2b: check acceptance is 2 cycles after the previous result handshake.
    task automatic run_block(input logic [511:0] b, input int d, input int stray,
                             input int hold, input bit b2b);
        logic [31:0]  win [16];
        logic [511:0] exp_res;
        logic         exp_to;
        int           n;
        int           last_i;
        bit           done_ok;

        blk_valid = 1'b1;
        blk_data  = b;
        n = 0;
        while (!blk_ready && n < 40) begin
            step();
            n++;
        end
        chk("accept_ready", blk_ready, 1'b1);
        if (b2b) chk("b2b_gap", 512'(cyc - last_hs), 512'd2);
        step();
        blk_valid = 1'b0;
        blk_data  = rand_block();
        // cycle A+1
        chk("ws_start_pulse", ws_start, 1'b1);
        chk("busy_start", busy, 1'b1);
        chk("blk_ready_start", blk_ready, 1'b0);
        step();
        // cycles A+2..A+17
        for (int k = 0; k < 16; k++) begin
            chk("ws_data_word", ws_data, b[32*k +: 32]);
            chk("ws_start_low", ws_start, 1'b0);
            ws_done   = (k == stray);
            ws_result = $urandom;
            step();
        end
        ws_done = 1'b0;

        for (int k = 0; k < 16; k++) win[k] = b[32*k +: 32] ^ XKEY;
        done_ok = (d >= 15) && (d < TO);
        last_i  = done_ok ? d : TO - 1;
        for (int i = 0; i <= last_i; i++) begin
            chk("wait_no_valid", res_valid, 1'b0);
            if (i == 0) chk("ws_data_zero", ws_data, 32'd0);
            if (done_ok && i >= d - 15) ws_result = win[i - (d - 15)];
            else                        ws_result = $urandom;
            ws_done = done_ok && (i == d);
            step();
        end
        ws_done   = 1'b0;
        ws_result = $urandom;

        exp_to = !done_ok;
        exp_res = '0;
        if (done_ok) for (int k = 0; k < 16; k++) exp_res[32*k +: 32] = win[k];
        chk("res_valid", res_valid, 1'b1);
        chk("res_timeout", res_timeout, exp_to);
        chk("res_data", res_data, exp_res);

        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            blk_valid = (h == hold / 2);
            blk_data  = rand_block();
            step();
            blk_valid = 1'b0;
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_data", res_data, exp_res);
            chk("hold_timeout", res_timeout, exp_to);
            chk("hold_blk_ready", blk_ready, 1'b0);
        end
        res_ready = 1'b1;
        last_hs = cyc;
        step();
        chk("post_hs_valid", res_valid, 1'b0);
        chk("post_hs_timeout", res_timeout, 1'b0);
        chk("post_hs_busy", busy, 1'b0);
        chk("post_hs_blk_ready", blk_ready, 1'b0);
        chk("post_hs_no_start", ws_start, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_blk_ready"}, blk_ready, 1'b0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_timeout"}, res_timeout, 1'b0);
        chk({tag, "_res_data"}, res_data, '0);
        chk({tag, "_ws_start"}, ws_start, 1'b0);
        chk({tag, "_ws_data"}, ws_data, 32'd0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] b;
        int n;

        rst = 1'b1; blk_valid = 1'b0; blk_data = '0; res_ready = 1'b0;
        ws_result = '0; ws_done = 1'b0;
        step();
        step();
        check_reset_values("reset");
        rst = 1'b0;
        chk("ready_before_first_edge", blk_ready, 1'b0);
        step();
        chk("ready_after_release", blk_ready, 1'b1);

        // Single block with the plan's counting pattern.
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'h01000000 + k;
        run_block(b, 19, -1, 0, 1'b0);

        // Backpressure with a blk_valid pulse during HOLD.
        run_block(rand_block(), 19, -1, 10, 1'b0);

        // Back-to-back with res_ready left high.
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'h00000000 + k;
        run_block(b, 19, -1, 0, 1'b0);
        for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'hFFFFFFFF - k;
        run_block(b, 19, -1, 0, 1'b1);

        // Timeout: done never arrives.
        run_block(rand_block(), -1, -1, 2, 1'b0);

        // Reset during SEND at word 7.
        b = rand_block();
        blk_valid = 1'b1;
        blk_data  = b;
        n = 0;
        while (!blk_ready && n < 40) begin
            step();
            n++;
        end
        step();
        blk_valid = 1'b0;
        step();
        for (int k = 0; k < 7; k++) step();
        chk("rst_word7_data", ws_data, b[32*7 +: 32]);
        #1 rst = 1'b1;
        #1 check_reset_values("midrst");
        step();
        step();
        rst = 1'b0;
        run_block(rand_block(), 19, -1, 1, 1'b0);

        // Stray done in SEND, then done on the final timeout cycle.
        run_block(rand_block(), TO - 1, 5, 1, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            int d;
            int stray;
            d     = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(15, TO - 1));
            stray = int'($urandom_range(0, 20)) - 4;
            if (stray > 15) stray = -1;
            run_block(rand_block(), d, stray, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
